apb_req_arbiter: RTL and testbench

- Shares the single APB master FSM request/response port among NUM_REQ command sources using round-robin arbitration.
- Decodes each granted address into the one-hot PSEL vector the FSM expects.
- Keeps exactly one transaction outstanding and routes its response back to the granted source.
- Sits between the per-source command FIFOs and the APB master FSM, all on the PCLK domain.

---
 rtl/apb_bridge_pkg.sv | 20 ++
 rtl/apb_req_arbiter_rr_grant.sv | 33 +++
 rtl/apb_req_arbiter.sv | 165 ++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the APB bridge: response codes and arbiter states.
package apb_bridge_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_ISSUE    = 2'd1,
    ARB_WAIT_RSP = 2'd2,
    ARB_DECERR   = 2'd3
  } arb_state_t;

  // Width of an index field able to address n items (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : apb_bridge_pkg

// File: rtl/apb_req_arbiter_rr_grant.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr, wrapping.
module rr_grant
  import apb_bridge_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_vec,
  input  logic [PW-1:0]      rr_ptr,
  output logic [PW-1:0]      grant_idx,
  output logic               any_valid
);

  // Scan from the pointer upward; the first hit wins.
  always_comb begin
    int unsigned cand;
    logic [NUM_REQ-1:0] shifted;
    grant_idx = '0;
    any_valid = 1'b0;
    cand      = 0;
    shifted   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      shifted = req_vec >> cand;
      if (!any_valid && shifted[0]) begin
        any_valid = 1'b1;
        grant_idx = PW'(cand);
      end
    end
  end

endmodule : rr_grant

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master FSM port among NUM_REQ command sources.
module apb_req_arbiter
  import apb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned NUM_APB_SLAVES = 4,
  parameter int unsigned SEL_LSB        = 12
) (
  input  logic                            PCLK,
  input  logic                            PRESETn,
  input  logic [NUM_REQ-1:0]              s_req_valid,
  output logic [NUM_REQ-1:0]              s_req_ready,
  input  logic [NUM_REQ-1:0]              s_req_is_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_req_wdata,
  output logic [NUM_REQ-1:0]              s_rsp_valid,
  input  logic [NUM_REQ-1:0]              s_rsp_ready,
  output logic                            s_rsp_is_write,
  output logic [DATA_WIDTH-1:0]           s_rsp_rdata,
  output logic [1:0]                      s_rsp_resp,
  output logic                            req_valid,
  input  logic                            req_ready,
  output logic                            req_is_write,
  output logic [ADDR_WIDTH-1:0]           req_addr,
  output logic [DATA_WIDTH-1:0]           req_wdata,
  output logic [NUM_APB_SLAVES-1:0]       req_psel_onehot,
  input  logic                            rsp_valid,
  output logic                            rsp_ready,
  input  logic                            rsp_is_write,
  input  logic [DATA_WIDTH-1:0]           rsp_rdata,
  input  logic [1:0]                      rsp_resp,
  output logic                            busy
);

  localparam int unsigned PW = idx_width(NUM_REQ);
  localparam int unsigned SW = idx_width(NUM_APB_SLAVES);

  arb_state_t                state;
  logic [PW-1:0]             rr_ptr;
  logic [PW-1:0]             grant_q;
  logic                      lat_is_write;
  logic [ADDR_WIDTH-1:0]     lat_addr;
  logic [DATA_WIDTH-1:0]     lat_wdata;
  logic [NUM_APB_SLAVES-1:0] lat_psel;

  logic [PW-1:0]             grant_idx;
  logic                      any_valid;
  logic                      win_is_write;
  logic [ADDR_WIDTH-1:0]     win_addr;
  logic [DATA_WIDTH-1:0]     win_wdata;
  logic [SW-1:0]             win_idx;
  logic                      win_in_range;
  logic [NUM_APB_SLAVES-1:0] win_psel;
  logic [NUM_REQ-1:0]        owner_mask;
  logic                      owner_rsp_ready;
  logic [PW-1:0]             next_ptr;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr_grant (
    .req_vec   (s_req_valid),
    .rr_ptr    (rr_ptr),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  // Select the winner's fields and decode its slave index.
  always_comb begin
    win_addr     = ADDR_WIDTH'(s_req_addr >> (32'(grant_idx) * ADDR_WIDTH));
    win_wdata    = DATA_WIDTH'(s_req_wdata >> (32'(grant_idx) * DATA_WIDTH));
    win_is_write = |(s_req_is_write & (NUM_REQ'(1) << grant_idx));
    win_idx      = SW'(win_addr >> SEL_LSB);
    win_in_range = (32'(win_idx) < NUM_APB_SLAVES);
    win_psel     = NUM_APB_SLAVES'(1) << win_idx;
    owner_mask      = NUM_REQ'(1) << grant_q;
    owner_rsp_ready = |(s_rsp_ready & owner_mask);
    next_ptr        = (32'(grant_q) == NUM_REQ - 1) ? '0 : PW'(grant_q + PW'(1));
  end

  // Arbiter state machine and latched transaction.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state        <= ARB_IDLE;
      rr_ptr       <= '0;
      grant_q      <= '0;
      lat_is_write <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_psel     <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_valid) begin
            grant_q      <= grant_idx;
            lat_is_write <= win_is_write;
            lat_addr     <= win_addr;
            lat_wdata    <= win_wdata;
            if (win_in_range) begin
              lat_psel <= win_psel;
              state    <= ARB_ISSUE;
            end else begin
              lat_psel <= '0;
              state    <= ARB_DECERR;
            end
          end
        end
        ARB_ISSUE: begin
          if (req_ready) state <= ARB_WAIT_RSP;
        end
        ARB_WAIT_RSP: begin
          if (rsp_valid && owner_rsp_ready) begin
            rr_ptr <= next_ptr;
            state  <= ARB_IDLE;
          end
        end
        ARB_DECERR: begin
          if (owner_rsp_ready) begin
            rr_ptr <= next_ptr;
            state  <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Port outputs decoded from state and the latched transaction.
  always_comb begin
    s_req_ready     = '0;
    s_rsp_valid     = '0;
    s_rsp_is_write  = 1'b0;
    s_rsp_rdata     = '0;
    s_rsp_resp      = RESP_OKAY;
    req_valid       = (state == ARB_ISSUE);
    req_is_write    = lat_is_write;
    req_addr        = lat_addr;
    req_wdata       = lat_wdata;
    req_psel_onehot = lat_psel;
    rsp_ready       = 1'b0;
    busy            = (state != ARB_IDLE);
    case (state)
      ARB_IDLE: begin
        // Gated by reset so sources see no accept while the block is held.
        if (PRESETn && any_valid) s_req_ready = NUM_REQ'(1) << grant_idx;
      end
      ARB_WAIT_RSP: begin
        s_rsp_valid    = rsp_valid ? owner_mask : '0;
        s_rsp_is_write = rsp_is_write;
        s_rsp_rdata    = rsp_rdata;
        s_rsp_resp     = rsp_resp;
        rsp_ready      = owner_rsp_ready;
      end
      ARB_DECERR: begin
        s_rsp_valid    = owner_mask;
        s_rsp_is_write = lat_is_write;
        s_rsp_resp     = RESP_DECERR;
      end
      default: ;
    endcase
  end

endmodule : apb_req_arbiter

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter.
module tb_apb_req_arbiter;
  import apb_bridge_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 2;
  // Three slaves leave select code 3 unused, so the decode-error path is reachable.
  localparam int unsigned NS = 3;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic [NR-1:0] s_req_valid, s_req_ready, s_req_is_write;
  logic [NR*AW-1:0] s_req_addr;
  logic [NR*DW-1:0] s_req_wdata;
  logic [NR-1:0] s_rsp_valid, s_rsp_ready;
  logic          s_rsp_is_write;
  logic [DW-1:0] s_rsp_rdata;
  logic [1:0]    s_rsp_resp;
  logic          req_valid, req_ready, req_is_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [NS-1:0] req_psel_onehot;
  logic          rsp_valid, rsp_ready, rsp_is_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          busy;

  int tests_run = 0;
  int tests_failed = 0;

  apb_req_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR),
    .NUM_APB_SLAVES(NS), .SEL_LSB(12)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_is_write(s_req_is_write), .s_req_addr(s_req_addr),
    .s_req_wdata(s_req_wdata), .s_rsp_valid(s_rsp_valid),
    .s_rsp_ready(s_rsp_ready), .s_rsp_is_write(s_rsp_is_write),
    .s_rsp_rdata(s_rsp_rdata), .s_rsp_resp(s_rsp_resp),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_write(req_is_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_psel_onehot(req_psel_onehot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_is_write(rsp_is_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge PCLK); #1;
  endtask

  // Stimulus helper: lets the FSM side complete whatever is in flight.
  task automatic finish_txn(output bit ok);
    ok = 1'b0;
    req_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = '0; rsp_resp = RESP_OKAY;
    s_rsp_ready = 2'b11;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (!busy) begin ok = 1'b1; break; end
    end
    req_ready = 1'b0; rsp_valid = 1'b0; s_rsp_ready = 2'b00;
  endtask

  task automatic do_reset();
    PRESETn = 1'b0;
    step(); step();
    PRESETn = 1'b1;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    s_req_valid = 2'b11; s_req_is_write = 2'b11;
    s_req_addr = {32'h0000_1000, 32'h0000_2000}; s_req_wdata = '1;
    s_rsp_ready = 2'b11; req_ready = 1'b1; rsp_valid = 1'b1;
    rsp_is_write = 1'b1; rsp_rdata = 32'hFFFF_FFFF; rsp_resp = 2'b11;
    step();
    @(negedge PCLK);
    tests_run++;
    if ({s_req_ready, s_rsp_valid, req_valid, rsp_ready, busy, s_rsp_is_write,
         s_rsp_rdata, s_rsp_resp, req_is_write, req_addr, req_wdata, req_psel_onehot} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: s_req_ready=%b s_rsp_valid=%b req_valid=%b rsp_ready=%b busy=%b req_addr=%h s_rsp_rdata=%h expected all 0",
               s_req_ready, s_rsp_valid, req_valid, rsp_ready, busy, req_addr, s_rsp_rdata);
    end
    s_req_valid = 2'b00; s_rsp_ready = 2'b00; req_ready = 1'b0; rsp_valid = 1'b0;
    rsp_is_write = 1'b0; rsp_rdata = '0; rsp_resp = RESP_OKAY;
    step();
    PRESETn = 1'b1;
  endtask

  task automatic test_single_read();
    bit ok;
    step();
    s_req_valid = 2'b01; s_req_is_write = 2'b00;
    s_req_addr = {32'h0000_0000, 32'h0000_2010};
    @(negedge PCLK);
    tests_run++;
    if (s_req_ready !== 2'b01) begin
      tests_failed++; $display("FAIL single_grant: s_req_ready=%b expected 01", s_req_ready);
    end
    step();
    s_req_valid = 2'b00; req_ready = 1'b1;
    @(negedge PCLK);
    tests_run++;
    if (req_valid !== 1'b1 || req_addr !== 32'h0000_2010 || req_psel_onehot !== 3'b100 || req_is_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_issue: req_valid=%b addr=%h psel=%b wr=%b expected 1 00002010 100 0",
               req_valid, req_addr, req_psel_onehot, req_is_write);
    end
    step();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'hA5A5_0001; rsp_resp = RESP_OKAY;
    rsp_is_write = 1'b0; s_rsp_ready = 2'b01;
    @(negedge PCLK);
    tests_run++;
    if (s_rsp_valid !== 2'b01 || s_rsp_rdata !== 32'hA5A5_0001 || s_rsp_resp !== 2'b00 ||
        rsp_ready !== 1'b1 || req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_rsp: s_rsp_valid=%b rdata=%h resp=%b rsp_ready=%b req_valid=%b expected 01 a5a50001 00 1 0",
               s_rsp_valid, s_rsp_rdata, s_rsp_resp, rsp_ready, req_valid);
    end
    step();
    rsp_valid = 1'b0; s_rsp_ready = 2'b00;
    @(negedge PCLK);
    tests_run++;
    if (busy !== 1'b0 || s_rsp_valid !== 2'b00) begin
      tests_failed++; $display("FAIL single_done: busy=%b s_rsp_valid=%b expected 0 00", busy, s_rsp_valid);
    end
    ok = 1'b1;
  endtask

  task automatic test_contention();
    int grants;
    bit ok;
    logic [NR-1:0] exp_rdy;
    do_reset();
    s_req_valid = 2'b11; s_req_is_write = 2'b00;
    s_req_addr = {32'h0000_1200, 32'h0000_0100};
    req_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = '0; rsp_resp = RESP_OKAY; s_rsp_ready = 2'b11;
    grants = 0;
    for (int c = 0; c < 60 && grants < 6; c++) begin
      @(negedge PCLK);
      if (s_req_ready !== 2'b00) begin
        exp_rdy = NR'(1) << (grants % 2);
        tests_run++;
        if (s_req_ready !== exp_rdy) begin
          tests_failed++;
          $display("FAIL contention_grant%0d: s_req_ready=%b expected %b", grants, s_req_ready, exp_rdy);
        end
        grants++;
      end
    end
    tests_run++;
    if (grants != 6) begin
      tests_failed++; $display("FAIL contention_count: grants=%0d expected 6", grants);
    end
    step();
    s_req_valid = 2'b00;
    finish_txn(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL contention_drain: busy=%b expected 0", busy); end
  endtask

  task automatic test_decerr();
    bit ok;
    step();
    s_req_valid = 2'b10; s_req_is_write = 2'b10;
    s_req_addr = {32'h0000_3000, 32'h0000_0040}; s_req_wdata = {32'h1111_2222, 32'h0};
    @(negedge PCLK);
    tests_run++;
    if (s_req_ready !== 2'b10) begin
      tests_failed++; $display("FAIL decerr_grant: s_req_ready=%b expected 10", s_req_ready);
    end
    step();
    s_req_valid = 2'b11; s_req_is_write = 2'b00;
    @(negedge PCLK);
    tests_run++;
    if (s_rsp_valid !== 2'b10 || s_rsp_resp !== RESP_DECERR || s_rsp_rdata !== 32'h0 ||
        s_rsp_is_write !== 1'b1 || req_valid !== 1'b0 || s_req_ready !== 2'b00 || rsp_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL decerr_rsp: s_rsp_valid=%b resp=%b rdata=%h wr=%b req_valid=%b s_req_ready=%b rsp_ready=%b expected 10 11 0 1 0 00 0",
               s_rsp_valid, s_rsp_resp, s_rsp_rdata, s_rsp_is_write, req_valid, s_req_ready, rsp_ready);
    end
    step();
    s_rsp_ready = 2'b10;
    @(negedge PCLK);
    tests_run++;
    if (req_valid !== 1'b0 || s_rsp_valid !== 2'b10 || rsp_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL decerr_hold: req_valid=%b s_rsp_valid=%b rsp_ready=%b expected 0 10 0", req_valid, s_rsp_valid, rsp_ready);
    end
    step();
    s_rsp_ready = 2'b00;
    @(negedge PCLK);
    tests_run++;
    if (s_req_ready !== 2'b01 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL decerr_next: s_req_ready=%b busy=%b expected 01 0", s_req_ready, busy);
    end
    step();
    s_req_valid = 2'b00;
    @(negedge PCLK);
    tests_run++;
    if (req_valid !== 1'b1 || req_addr !== 32'h0000_0040 || req_psel_onehot !== 3'b001) begin
      tests_failed++;
      $display("FAIL decerr_next_issue: req_valid=%b addr=%h psel=%b expected 1 00000040 001", req_valid, req_addr, req_psel_onehot);
    end
    finish_txn(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL decerr_drain: busy=%b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    step();
    s_req_valid = 2'b01; s_req_is_write = 2'b00;
    s_req_addr = {32'h0000_1004, 32'h0000_0008}; req_ready = 1'b1;
    step();
    s_req_valid = 2'b10;
    step();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'h1234_5678; rsp_resp = RESP_SLVERR;
    rsp_is_write = 1'b0; s_rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      tests_run++;
      if (rsp_ready !== 1'b0 || s_rsp_valid !== 2'b01 || s_rsp_rdata !== 32'h1234_5678 ||
          s_rsp_resp !== RESP_SLVERR || s_req_ready !== 2'b00 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL backpressure_hold%0d: rsp_ready=%b s_rsp_valid=%b rdata=%h resp=%b s_req_ready=%b busy=%b expected 0 01 12345678 10 00 1",
                 i, rsp_ready, s_rsp_valid, s_rsp_rdata, s_rsp_resp, s_req_ready, busy);
      end
      step();
    end
    s_rsp_ready = 2'b11;
    @(negedge PCLK);
    tests_run++;
    if (rsp_ready !== 1'b1 || s_rsp_valid !== 2'b01) begin
      tests_failed++; $display("FAIL backpressure_release: rsp_ready=%b s_rsp_valid=%b expected 1 01", rsp_ready, s_rsp_valid);
    end
    step();
    rsp_valid = 1'b0; s_rsp_ready = 2'b00;
    @(negedge PCLK);
    tests_run++;
    if (busy !== 1'b0 || s_req_ready !== 2'b10) begin
      tests_failed++; $display("FAIL backpressure_after: busy=%b s_req_ready=%b expected 0 10", busy, s_req_ready);
    end
    step();
    s_req_valid = 2'b00;
    finish_txn(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL backpressure_drain: busy=%b expected 0", busy); end
  endtask

  task automatic test_stall_and_reset();
    bit ok;
    step();
    s_req_valid = 2'b01; s_req_is_write = 2'b01;
    s_req_addr = {32'h0000_0000, 32'h0000_2ABC}; s_req_wdata = {32'h0, 32'hDEAD_BEEF};
    req_ready = 1'b0;
    step();
    s_req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) req_ready = 1'b1;
      @(negedge PCLK);
      tests_run++;
      if (req_valid !== 1'b1 || req_addr !== 32'h0000_2ABC || req_wdata !== 32'hDEAD_BEEF ||
          req_psel_onehot !== 3'b100 || req_is_write !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: req_valid=%b addr=%h wdata=%h psel=%b wr=%b expected 1 00002abc deadbeef 100 1",
                 i, req_valid, req_addr, req_wdata, req_psel_onehot, req_is_write);
      end
      step();
    end
    req_ready = 1'b0;
    @(negedge PCLK);
    tests_run++;
    if (req_valid !== 1'b0 || busy !== 1'b1 || s_rsp_valid !== 2'b00) begin
      tests_failed++; $display("FAIL stall_to_wait: req_valid=%b busy=%b s_rsp_valid=%b expected 0 1 00", req_valid, busy, s_rsp_valid);
    end
    rsp_valid = 1'b1; rsp_rdata = 32'h0BAD_0BAD; rsp_resp = RESP_OKAY; s_rsp_ready = 2'b00;
    s_req_valid = 2'b11; s_req_is_write = 2'b00;
    s_req_addr = {32'h0000_1000, 32'h0000_0004};
    #1;
    tests_run++;
    if (s_rsp_valid !== 2'b01) begin
      tests_failed++; $display("FAIL reset_pre: s_rsp_valid=%b expected 01", s_rsp_valid);
    end
    #1 PRESETn = 1'b0;
    #1;
    tests_run++;
    if ({s_req_ready, s_rsp_valid, req_valid, rsp_ready, busy, s_rsp_rdata, req_addr, req_wdata, req_psel_onehot} !== '0) begin
      tests_failed++;
      $display("FAIL reset_async: s_req_ready=%b s_rsp_valid=%b req_valid=%b rsp_ready=%b busy=%b rdata=%h addr=%h expected all 0",
               s_req_ready, s_rsp_valid, req_valid, rsp_ready, busy, s_rsp_rdata, req_addr);
    end
    step();
    PRESETn = 1'b1;
    @(negedge PCLK);
    tests_run++;
    if (s_req_ready !== 2'b01 || s_rsp_valid !== 2'b00 || rsp_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_regrant: s_req_ready=%b s_rsp_valid=%b rsp_ready=%b expected 01 00 0", s_req_ready, s_rsp_valid, rsp_ready);
    end
    step();
    s_req_valid = 2'b00; rsp_valid = 1'b0;
    @(negedge PCLK);
    tests_run++;
    if (req_valid !== 1'b1 || req_addr !== 32'h0000_0004 || req_psel_onehot !== 3'b001) begin
      tests_failed++;
      $display("FAIL reset_issue: req_valid=%b addr=%h psel=%b expected 1 00000004 001", req_valid, req_addr, req_psel_onehot);
    end
    finish_txn(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL reset_drain: busy=%b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_decerr();
    test_backpressure();
    test_stall_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_apb_req_arbiter
